// File: rtl/ibus_pkg.sv
// Shared types and constants for the jTDC internal register bus arbiter.
package ibus_pkg;

    // Default internal bus widths
    localparam int IBUS_ADDR_W = 16;
    localparam int IBUS_DATA_W = 32;

    // Read-latency counter width; holds READ_LATENCY-1 for latencies up to 15
    localparam int CNT_W = 4;

    // Requester identifiers
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } ibus_state_e;

    // Round-robin pick: a lone requester wins, on a tie the port that was not
    // served last wins.
    function automatic logic pick_port(input logic pend_a, input logic pend_b,
                                       input logic last);
        logic port;
        if (pend_a && pend_b) begin
            port = ~last;
        end else if (pend_b) begin
            port = PORT_B;
        end else begin
            port = PORT_A;
        end
        return port;
    endfunction

endpackage

// File: rtl/ibus_arbiter_if.sv
// Requester ports plus register-decoder side of the shared internal bus.
interface ibus_arbiter_if #(
    parameter int ADDR_W = ibus_pkg::IBUS_ADDR_W,
    parameter int DATA_W = ibus_pkg::IBUS_DATA_W
);
    // Port A (PCIe/AXI4 bridge)
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_done;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ovf;
    // Port B (init/calibration sequencer)
    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_done;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ovf;
    // Shared control
    logic              ovf_clr;
    logic              busy;
    // Register decoder side
    logic [ADDR_W-1:0] bus_address;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_write;
    logic              bus_read;
    logic [DATA_W-1:0] bus_rdata;

    // Arbiter view
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_done, a_rdata, a_ovf,
        input  b_req, b_we, b_addr, b_wdata,
        output b_done, b_rdata, b_ovf,
        input  ovf_clr,
        output busy,
        output bus_address, bus_wdata, bus_write, bus_read,
        input  bus_rdata
    );

    // Requester / decoder environment view
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_done, a_rdata, a_ovf,
        output b_req, b_we, b_addr, b_wdata,
        input  b_done, b_rdata, b_ovf,
        output ovf_clr,
        input  busy,
        input  bus_address, bus_wdata, bus_write, bus_read,
        output bus_rdata
    );

endinterface

// File: rtl/ibus_req_slot.sv
// One-deep request buffer for a single requester, with pending and sticky
// overflow tracking. A request is only accepted when the port has nothing
// pending and is not the owner of the access in progress.
module ibus_req_slot
    import ibus_pkg::*;
#(
    parameter int ADDR_W = IBUS_ADDR_W,
    parameter int DATA_W = IBUS_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              owned,
    input  logic              take,
    input  logic              ovf_clr,
    output logic              pend,
    output logic              buf_we,
    output logic [ADDR_W-1:0] buf_addr,
    output logic [DATA_W-1:0] buf_wdata,
    output logic              ovf
);

    logic              accept_s;
    logic              drop_s;
    logic              pend_r;
    logic              we_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              ovf_r;

    // Classify an incoming strobe as accepted or dropped
    always_comb begin
        accept_s = 1'b0;
        drop_s   = 1'b0;
        if (req) begin
            if (pend_r || owned) begin
                drop_s = 1'b1;
            end else begin
                accept_s = 1'b1;
            end
        end else begin
            accept_s = 1'b0;
            drop_s   = 1'b0;
        end
    end

    // Pending flag and request buffer; a take only happens while pending, so
    // it never coincides with an accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_r  <= 1'b0;
            we_r    <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            pend_r  <= 1'b1;
            we_r    <= we;
            addr_r  <= addr;
            wdata_r <= wdata;
        end else if (take) begin
            pend_r  <= 1'b0;
        end else begin
            pend_r  <= pend_r;
        end
    end

    // Sticky overflow; a new overflow beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (drop_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign pend      = pend_r;
    assign buf_we    = we_r;
    assign buf_addr  = addr_r;
    assign buf_wdata = wdata_r;
    assign ovf       = ovf_r;

endmodule

// File: rtl/ibus_arbiter.sv
// Two-requester arbiter for the jTDC internal register bus. Buffers one
// request per port, grants round-robin in IDLE, drives a single-beat access
// and returns a one-cycle done pulse with read data to the owning port.
module ibus_arbiter
    import ibus_pkg::*;
#(
    parameter int ADDR_W       = IBUS_ADDR_W,
    parameter int DATA_W       = IBUS_DATA_W,
    parameter int READ_LATENCY = 2
) (
    input  logic          sys_clk,
    input  logic          sys_rstn,
    ibus_arbiter_if.slave bus
);

    // WAIT counts down from here to zero, so bus_rdata is sampled exactly
    // READ_LATENCY cycles after the bus_read cycle
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    ibus_state_e       state_r;
    ibus_state_e       state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_next_s;
    logic              owner_r;
    logic              last_r;
    logic              acc_we_r;

    logic              grant_s;
    logic              grant_port_s;
    logic              take_a_s;
    logic              take_b_s;
    logic              own_a_s;
    logic              own_b_s;
    logic              rd_capture_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

    logic              pend_a_s;
    logic              pend_b_s;
    logic              buf_a_we_s;
    logic              buf_b_we_s;
    logic [ADDR_W-1:0] buf_a_addr_s;
    logic [ADDR_W-1:0] buf_b_addr_s;
    logic [DATA_W-1:0] buf_a_wdata_s;
    logic [DATA_W-1:0] buf_b_wdata_s;
    logic              ovf_a_s;
    logic              ovf_b_s;

    logic [ADDR_W-1:0] bus_address_r;
    logic [DATA_W-1:0] bus_wdata_r;
    logic              bus_write_r;
    logic              bus_read_r;
    logic              a_done_r;
    logic              b_done_r;
    logic [DATA_W-1:0] a_rdata_r;
    logic [DATA_W-1:0] b_rdata_r;
    logic              busy_r;

    ibus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_a (
        .clk       (sys_clk),
        .rst_n     (sys_rstn),
        .req       (bus.a_req),
        .we        (bus.a_we),
        .addr      (bus.a_addr),
        .wdata     (bus.a_wdata),
        .owned     (own_a_s),
        .take      (take_a_s),
        .ovf_clr   (bus.ovf_clr),
        .pend      (pend_a_s),
        .buf_we    (buf_a_we_s),
        .buf_addr  (buf_a_addr_s),
        .buf_wdata (buf_a_wdata_s),
        .ovf       (ovf_a_s)
    );

    ibus_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_slot_b (
        .clk       (sys_clk),
        .rst_n     (sys_rstn),
        .req       (bus.b_req),
        .we        (bus.b_we),
        .addr      (bus.b_addr),
        .wdata     (bus.b_wdata),
        .owned     (own_b_s),
        .take      (take_b_s),
        .ovf_clr   (bus.ovf_clr),
        .pend      (pend_b_s),
        .buf_we    (buf_b_we_s),
        .buf_addr  (buf_b_addr_s),
        .buf_wdata (buf_b_wdata_s),
        .ovf       (ovf_b_s)
    );

    // Ownership of the access in progress, used to drop re-requests
    always_comb begin
        own_a_s = (state_r != IDLE) && (owner_r == PORT_A);
        own_b_s = (state_r != IDLE) && (owner_r == PORT_B);
    end

    // Next-state, grant decision and buffer selection
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        grant_s      = 1'b0;
        grant_port_s = PORT_A;
        rd_capture_s = 1'b0;
        take_a_s     = 1'b0;
        take_b_s     = 1'b0;
        sel_we_s     = 1'b0;
        sel_addr_s   = '0;
        sel_wdata_s  = '0;

        case (state_r)
            IDLE: begin
                if (pend_a_s || pend_b_s) begin
                    grant_s      = 1'b1;
                    grant_port_s = pick_port(pend_a_s, pend_b_s, last_r);
                    state_next_s = ACCESS;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACCESS: begin
                if (acc_we_r) begin
                    state_next_s = DONE;
                end else begin
                    cnt_next_s   = CNT_LOAD;
                    state_next_s = WAIT;
                end
            end
            WAIT: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    rd_capture_s = 1'b1;
                    state_next_s = DONE;
                end else begin
                    cnt_next_s   = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase

        if (grant_port_s == PORT_B) begin
            sel_we_s    = buf_b_we_s;
            sel_addr_s  = buf_b_addr_s;
            sel_wdata_s = buf_b_wdata_s;
        end else begin
            sel_we_s    = buf_a_we_s;
            sel_addr_s  = buf_a_addr_s;
            sel_wdata_s = buf_a_wdata_s;
        end

        take_a_s = grant_s && (grant_port_s == PORT_A);
        take_b_s = grant_s && (grant_port_s == PORT_B);
    end

    // FSM state and read-latency counter
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Grant bookkeeping; address and data stay put until the next grant
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            owner_r       <= PORT_A;
            last_r        <= PORT_B;
            acc_we_r      <= 1'b0;
            bus_address_r <= '0;
            bus_wdata_r   <= '0;
        end else if (grant_s) begin
            owner_r       <= grant_port_s;
            last_r        <= grant_port_s;
            acc_we_r      <= sel_we_s;
            bus_address_r <= sel_addr_s;
            bus_wdata_r   <= sel_wdata_s;
        end else begin
            owner_r       <= owner_r;
            last_r        <= last_r;
        end
    end

    // Strobes high only in ACCESS, done high only in DONE, busy outside IDLE
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            bus_write_r <= 1'b0;
            bus_read_r  <= 1'b0;
            a_done_r    <= 1'b0;
            b_done_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            bus_write_r <= grant_s && sel_we_s;
            bus_read_r  <= grant_s && !sel_we_s;
            a_done_r    <= (state_next_s == DONE) && (owner_r == PORT_A);
            b_done_r    <= (state_next_s == DONE) && (owner_r == PORT_B);
            busy_r      <= (state_next_s != IDLE);
        end
    end

    // Read data capture into the owning port; writes leave it untouched
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            a_rdata_r <= '0;
            b_rdata_r <= '0;
        end else if (rd_capture_s) begin
            if (owner_r == PORT_B) begin
                b_rdata_r <= bus.bus_rdata;
            end else begin
                a_rdata_r <= bus.bus_rdata;
            end
        end else begin
            a_rdata_r <= a_rdata_r;
            b_rdata_r <= b_rdata_r;
        end
    end

    assign bus.bus_address = bus_address_r;
    assign bus.bus_wdata   = bus_wdata_r;
    assign bus.bus_write   = bus_write_r;
    assign bus.bus_read    = bus_read_r;
    assign bus.a_done      = a_done_r;
    assign bus.b_done      = b_done_r;
    assign bus.a_rdata     = a_rdata_r;
    assign bus.b_rdata     = b_rdata_r;
    assign bus.a_ovf       = ovf_a_s;
    assign bus.b_ovf       = ovf_b_s;
    assign bus.busy        = busy_r;

endmodule

// File: tb/tb_ibus_arbiter.sv
// Bench for ibus_arbiter: three instances (READ_LATENCY 2, 1, 15) share one
// stimulus stream and are each compared every cycle with a timestamp-based
// transaction model; a directed table and a few hand sequences sit on top.
module tb_ibus_arbiter;
    import ibus_pkg::*;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int NI = 3;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0, ovf_clr = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0;
    logic [DW-1:0] a_wdata = '0, b_wdata = '0;
    int cyc  = 0;
    int nvec = 0;
    int nmis = 0;

    logic [NI-1:0] o_a_done, o_b_done, o_a_ovf, o_b_ovf, o_bw, o_br, o_busy;
    logic [DW-1:0] o_a_rdata [NI];
    logic [DW-1:0] o_b_rdata [NI];
    logic [DW-1:0] o_wdata   [NI];
    logic [AW-1:0] o_addr    [NI];

    always #5 clk = ~clk;

    function automatic int lat_of(input int k);
        return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
    endfunction

    // Register decoder stand-in: address 0 is an ID register, elsewhere the
    // data encodes the current cycle so the sample cycle is visible
    function automatic logic [DW-1:0] decode(input int c, input logic [AW-1:0] a);
        logic [31:0] cc;
        cc = c;
        if (a == 16'h0000) return 32'h0000_0401;
        return {cc[15:0], a};
    endfunction

    for (genvar k = 0; k < NI; k++) begin : g_inst
        localparam int LAT = (k == 0) ? 2 : ((k == 1) ? 1 : 15);
        ibus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
        assign ifc.a_req     = a_req;
        assign ifc.a_we      = a_we;
        assign ifc.a_addr    = a_addr;
        assign ifc.a_wdata   = a_wdata;
        assign ifc.b_req     = b_req;
        assign ifc.b_we      = b_we;
        assign ifc.b_addr    = b_addr;
        assign ifc.b_wdata   = b_wdata;
        assign ifc.ovf_clr   = ovf_clr;
        assign ifc.bus_rdata = decode(cyc, ifc.bus_address);
        ibus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(LAT)) dut (
            .sys_clk  (clk),
            .sys_rstn (rstn),
            .bus      (ifc)
        );
        assign o_a_done[k]  = ifc.a_done;
        assign o_b_done[k]  = ifc.b_done;
        assign o_a_ovf[k]   = ifc.a_ovf;
        assign o_b_ovf[k]   = ifc.b_ovf;
        assign o_bw[k]      = ifc.bus_write;
        assign o_br[k]      = ifc.bus_read;
        assign o_busy[k]    = ifc.busy;
        assign o_a_rdata[k] = ifc.a_rdata;
        assign o_b_rdata[k] = ifc.b_rdata;
        assign o_wdata[k]   = ifc.bus_wdata;
        assign o_addr[k]    = ifc.bus_address;
    end

    // ---------------- transaction model (cycle timestamps) ----------------
    bit            m_pend [NI][2];
    bit            m_bwe  [NI][2];
    logic [AW-1:0] m_badr [NI][2];
    logic [DW-1:0] m_bwd  [NI][2];
    bit            m_ovf  [NI][2];
    logic [DW-1:0] m_rd   [NI][2];
    bit            m_act  [NI];
    int            m_own  [NI];
    int            m_last [NI];
    bit            m_we   [NI];
    int            m_sc   [NI];
    int            m_dc   [NI];
    logic [AW-1:0] m_addr [NI];
    logic [DW-1:0] m_wd   [NI];

    task automatic model_reset(input int k);
        for (int p = 0; p < 2; p++) begin
            m_pend[k][p] = 0; m_bwe[k][p] = 0; m_badr[k][p] = '0;
            m_bwd[k][p] = '0; m_ovf[k][p] = 0; m_rd[k][p] = '0;
        end
        m_act[k] = 0; m_own[k] = 0; m_last[k] = 1; m_we[k] = 0;
        m_sc[k] = -1; m_dc[k] = -1; m_addr[k] = '0; m_wd[k] = '0;
    endtask

    // Advance instance k over the current cycle using the driven inputs
    task automatic model_advance(input int k);
        bit p0 [2];
        bit req [2];
        bit we [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        bit act0;
        int own0;
        int c;
        if (!rstn) begin
            model_reset(k);
            return;
        end
        c = cyc;
        req[0] = a_req; we[0] = a_we; ad[0] = a_addr; wd[0] = a_wdata;
        req[1] = b_req; we[1] = b_we; ad[1] = b_addr; wd[1] = b_wdata;
        p0[0] = m_pend[k][0]; p0[1] = m_pend[k][1];
        act0 = m_act[k];
        own0 = m_own[k];
        if (act0 && !m_we[k] && (c + 1 == m_dc[k])) m_rd[k][own0] = decode(c, m_addr[k]);
        if (act0 && (c == m_dc[k])) m_act[k] = 0;
        if (!act0 && (p0[0] || p0[1])) begin
            int p;
            p = (p0[0] && p0[1]) ? (1 - m_last[k]) : (p0[0] ? 0 : 1);
            m_act[k] = 1; m_own[k] = p; m_last[k] = p;
            m_we[k] = m_bwe[k][p]; m_addr[k] = m_badr[k][p]; m_wd[k] = m_bwd[k][p];
            m_sc[k] = c + 1;
            m_dc[k] = c + 2 + (m_bwe[k][p] ? 0 : lat_of(k));
            m_pend[k][p] = 0;
        end
        for (int x = 0; x < 2; x++) begin
            bit set;
            set = 0;
            if (req[x]) begin
                if (p0[x] || (act0 && own0 == x)) begin
                    set = 1;
                end else begin
                    m_pend[k][x] = 1; m_bwe[k][x] = we[x];
                    m_badr[k][x] = ad[x]; m_bwd[k][x] = wd[x];
                end
            end
            if (set) m_ovf[k][x] = 1;
            else if (ovf_clr) m_ovf[k][x] = 0;
        end
    endtask

    task automatic chk(input string nm, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    task automatic check_inst(input int k);
        chk("bus_write", k, 32'(o_bw[k]),     32'(m_act[k] && cyc == m_sc[k] && m_we[k]));
        chk("bus_read",  k, 32'(o_br[k]),     32'(m_act[k] && cyc == m_sc[k] && !m_we[k]));
        chk("busy",      k, 32'(o_busy[k]),   32'(m_act[k]));
        chk("a_done",    k, 32'(o_a_done[k]), 32'(m_act[k] && cyc == m_dc[k] && m_own[k] == 0));
        chk("b_done",    k, 32'(o_b_done[k]), 32'(m_act[k] && cyc == m_dc[k] && m_own[k] == 1));
        chk("a_ovf",     k, 32'(o_a_ovf[k]),  32'(m_ovf[k][0]));
        chk("b_ovf",     k, 32'(o_b_ovf[k]),  32'(m_ovf[k][1]));
        chk("a_rdata",   k, o_a_rdata[k],     m_rd[k][0]);
        chk("b_rdata",   k, o_b_rdata[k],     m_rd[k][1]);
        chk("bus_addr",  k, 32'(o_addr[k]),   32'(m_addr[k]));
        chk("bus_wdata", k, o_wdata[k],       m_wd[k]);
    endtask

    task automatic tick();
        for (int k = 0; k < NI; k++) model_advance(k);
        @(posedge clk);
        #1;
        cyc++;
        for (int k = 0; k < NI; k++) check_inst(k);
    endtask

    task automatic clear_inputs();
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        ovf_clr = 1'b0;
    endtask

    task automatic hold_reset(input int n);
        rstn = 1'b0;
        clear_inputs();
        for (int k = 0; k < NI; k++) model_reset(k);
        repeat (n) tick();
        rstn = 1'b1;
    endtask

    // ---------------- directed table (READ_LATENCY=2 instance) ----------------
    typedef struct {
        logic          a_req;
        logic          a_we;
        logic [AW-1:0] a_addr;
        logic [DW-1:0] a_wd;
        logic          b_req;
        logic          b_we;
        logic [AW-1:0] b_addr;
        logic [DW-1:0] b_wd;
        logic          clr;
        logic [5:0]    exp;   // {bus_write, bus_read, a_done, b_done, busy, a_ovf}
    } vec_t;

    vec_t tbl [24];

    initial begin
        logic [5:0] ex_s [24];
        ex_s = '{6'b000000, 6'b000000, 6'b100010, 6'b001010, 6'b000000, 6'b000000,
                 6'b010010, 6'b000010, 6'b000010, 6'b000110, 6'b000000, 6'b000000,
                 6'b010010, 6'b000010, 6'b000010, 6'b001010, 6'b000000, 6'b100010,
                 6'b000110, 6'b000000, 6'b000000, 6'b100011, 6'b001010, 6'b000000};
        for (int i = 0; i < 24; i++) begin
            tbl[i] = '{1'b0, 1'b0, 16'h0000, 32'h0000_0000, 1'b0, 1'b0, 16'h0000,
                       32'h0000_0000, 1'b0, ex_s[i]};
        end
        // write A
        tbl[0].a_req = 1'b1; tbl[0].a_we = 1'b1; tbl[0].a_addr = 16'h0010; tbl[0].a_wd = 32'hDEAD_BEEF;
        // read B of the ID register
        tbl[4].b_req = 1'b1; tbl[4].b_we = 1'b0; tbl[4].b_addr = 16'h0000;
        // simultaneous pair after B was last served: A first
        tbl[10].a_req = 1'b1; tbl[10].a_we = 1'b0; tbl[10].a_addr = 16'h0020;
        tbl[10].b_req = 1'b1; tbl[10].b_we = 1'b1; tbl[10].b_addr = 16'h0030; tbl[10].b_wd = 32'h1234_5678;
        // back-to-back A: second one overflows and is dropped
        tbl[19].a_req = 1'b1; tbl[19].a_we = 1'b1; tbl[19].a_addr = 16'h0040; tbl[19].a_wd = 32'h0000_0001;
        tbl[20].a_req = 1'b1; tbl[20].a_we = 1'b1; tbl[20].a_addr = 16'h0050; tbl[20].a_wd = 32'h0000_0002;
        tbl[21].clr = 1'b1;

        hold_reset(3);

        for (int i = 0; i < 24; i++) begin
            chk("tbl_vec", i, 32'({o_bw[0], o_br[0], o_a_done[0], o_b_done[0], o_busy[0], o_a_ovf[0]}),
                32'(tbl[i].exp));
            a_req = tbl[i].a_req; a_we = tbl[i].a_we; a_addr = tbl[i].a_addr; a_wdata = tbl[i].a_wd;
            b_req = tbl[i].b_req; b_we = tbl[i].b_we; b_addr = tbl[i].b_addr; b_wdata = tbl[i].b_wd;
            ovf_clr = tbl[i].clr;
            tick();
        end
        clear_inputs();
        chk("b_rdata_id", 0, o_b_rdata[0], 32'h0000_0401);
        chk("ovf_kept_first_addr", 0, 32'(o_addr[0]), 32'h0000_0040);

        // simultaneous pair straight out of reset: A done at T+3, B at T+6
        hold_reset(2);
        a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0A0A; a_wdata = 32'hAAAA_0001;
        b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0B0B; b_wdata = 32'hBBBB_0002;
        tick();
        clear_inputs();
        tick(); tick();
        chk("pair_a_first", 0, 32'({o_a_done[0], o_b_done[0]}), 32'h0000_0002);
        tick(); tick(); tick();
        chk("pair_b_second", 0, 32'({o_a_done[0], o_b_done[0]}), 32'h0000_0001);
        repeat (3) tick();

        // randomized traffic, light load
        for (int i = 0; i < 1500; i++) begin
            a_req   = ($urandom_range(0, 3) == 0);
            a_we    = 1'($urandom_range(0, 1));
            a_addr  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            a_wdata = $urandom;
            b_req   = ($urandom_range(0, 3) == 0);
            b_we    = 1'($urandom_range(0, 1));
            b_addr  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            b_wdata = $urandom;
            ovf_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        // heavy contention: both ports requesting almost every cycle
        for (int i = 0; i < 600; i++) begin
            a_req   = ($urandom_range(0, 7) != 0);
            a_we    = 1'($urandom_range(0, 1));
            a_addr  = 16'($urandom);
            a_wdata = $urandom;
            b_req   = ($urandom_range(0, 7) != 0);
            b_we    = 1'($urandom_range(0, 1));
            b_addr  = 16'($urandom);
            b_wdata = $urandom;
            ovf_clr = ($urandom_range(0, 3) == 0);
            tick();
        end
        clear_inputs();
        repeat (20) tick();

        // reset in the middle of a read: outputs drop at once, then recover
        hold_reset(2);
        a_req = 1'b1; a_we = 1'b0; a_addr = 16'h0100;
        tick();
        clear_inputs();
        repeat (3) tick();
        #2;
        rstn = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            chk("rst_strobes", k, 32'({o_bw[k], o_br[k]}), 32'h0000_0000);
            chk("rst_done",    k, 32'({o_a_done[k], o_b_done[k]}), 32'h0000_0000);
            chk("rst_busy",    k, 32'(o_busy[k]), 32'h0000_0000);
        end
        for (int k = 0; k < NI; k++) model_reset(k);
        repeat (2) tick();
        rstn = 1'b1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 16'h0200;
        tick();
        clear_inputs();
        repeat (22) tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
